// File: rtl/strobe_rx_mux.sv
// strobe_rx_mux: destination-domain receiver for toggle-flag strobe crossings.
// Each channel's toggle flag is synchronised through a DELAY-flop chain, every
// detected toggle captures that channel's data word into a hold register, and
// all channels are merged onto one registered valid/ready output stream.
// Sticky per-channel overflow flags record words replaced before delivery.
// Optional feature macro: STROBE_RX_RR_EN selects round-robin arbitration;
// when it is undefined the lowest pending channel index always wins.
module strobe_rx_mux #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int DELAY    = 2,
    parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk_out,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       toggle_in,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [CW-1:0]             out_chan,
    output logic [CHANNELS-1:0]       ovf_flags,
    input  logic                      ovf_clear
);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    logic [DELAY-1:0]    sync_q [CHANNELS];
    logic [CHANNELS-1:0] last_q;
    logic [CHANNELS-1:0] event_s;
    logic [WIDTH-1:0]    hold_q [CHANNELS];
    logic [CHANNELS-1:0] pending_q;
    logic [CHANNELS-1:0] pending_d;
    logic [CHANNELS-1:0] ovf_q;
    logic [CHANNELS-1:0] ovf_d;
    logic [CHANNELS-1:0] grant_s;
    logic                grant_en_s;
    logic [CW-1:0]       gnt_idx_s;
    logic [CW-1:0]       start_s;
    state_t              state_q;
    state_t              state_d;
    logic                out_valid_q;
    logic                out_valid_d;
    logic [WIDTH-1:0]    out_data_q;
    logic [WIDTH-1:0]    out_data_d;
    logic [CW-1:0]       out_chan_q;
    logic [CW-1:0]       out_chan_d;

    // First requesting channel found when scanning upward from start, wrapping.
    function automatic logic [CW-1:0] pick_first(input logic [CHANNELS-1:0] req,
                                                 input logic [CW-1:0]       start);
        logic [CW-1:0] sel;
        logic          found;
        int            idx;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            idx = int'(start) + i;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = CW'(idx);
            end
        end
        return sel;
    endfunction

    // Synchroniser chains plus the previous synchronised value for edge detection.
    always_ff @(posedge clk_out) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                sync_q[c] <= '0;
            end
            last_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                sync_q[c] <= {sync_q[c][DELAY-2:0], toggle_in[c]};
                last_q[c] <= sync_q[c][DELAY-1];
            end
        end
    end

    // A toggle event is any change of the synchronised flag.
    always_comb begin
        event_s = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            event_s[c] = sync_q[c][DELAY-1] ^ last_q[c];
        end
    end

    // Capture the channel word on every event; the newest word always wins.
    always_ff @(posedge clk_out) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                hold_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (event_s[c]) begin
                    hold_q[c] <= data_in[c*WIDTH +: WIDTH];
                end
            end
        end
    end

`ifdef STROBE_RX_RR_EN
    logic [CW-1:0] ptr_q;
    logic [CW-1:0] ptr_d;

    // Round-robin pointer names the channel after the last grant.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_en_s) begin
            ptr_d = (gnt_idx_s == CW'(CHANNELS - 1)) ? '0 : gnt_idx_s + CW'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Round-robin pointer register, moved only by a grant.
    always_ff @(posedge clk_out) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign start_s = ptr_q;
`else
    assign start_s = '0;
`endif

    // Output FSM: grant from IDLE or on accept, hold the word while stalled.
    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        grant_en_s  = 1'b0;
        gnt_idx_s   = pick_first(pending_q, start_s);
        case (state_q)
            ST_IDLE: begin
                if (|pending_q) begin
                    grant_en_s = 1'b1;
                    state_d    = ST_PRESENT;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    if (|pending_q) begin
                        grant_en_s = 1'b1;
                        state_d    = ST_PRESENT;
                    end else begin
                        state_d    = ST_IDLE;
                    end
                end else begin
                    state_d = ST_PRESENT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (grant_en_s) begin
            out_data_d = hold_q[gnt_idx_s];
            out_chan_d = gnt_idx_s;
        end else begin
            out_data_d = out_data_q;
            out_chan_d = out_chan_q;
        end
        out_valid_d = (state_d == ST_PRESENT);
    end

    // Pending and overflow next state; a same-cycle event beats both grant and clear.
    always_comb begin
        grant_s   = grant_en_s ? (CHANNELS'(1) << gnt_idx_s) : '0;
        pending_d = event_s | (pending_q & ~grant_s);
        ovf_d     = (ovf_q & ~{CHANNELS{ovf_clear}}) | (event_s & pending_q & ~grant_s);
    end

    // State, output and bookkeeping registers.
    always_ff @(posedge clk_out) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            pending_q   <= '0;
            ovf_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            pending_q   <= pending_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign ovf_flags = ovf_q;

endmodule

// File: tb/tb_strobe_rx_mux.sv
// Testbench for strobe_rx_mux: table-driven vectors, directed corner cases and
// a randomized run checked against a word-slot reference model.
module tb_strobe_rx_mux;

    localparam int CH = 4;
    localparam int W  = 8;
    localparam int DL = 2;

    logic            clk_out = 1'b0;
    logic            rst;
    logic [CH-1:0]   toggle_in;
    logic [CH*W-1:0] data_in;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_data;
    logic [1:0]      out_chan;
    logic [CH-1:0]   ovf_flags;
    logic            ovf_clear;

    always #5 clk_out = ~clk_out;

    strobe_rx_mux #(.CHANNELS(CH), .WIDTH(W), .DELAY(DL)) dut (
        .clk_out   (clk_out),
        .rst       (rst),
        .toggle_in (toggle_in),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .ovf_flags (ovf_flags),
        .ovf_clear (ovf_clear)
    );

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model: one word slot per channel ----------------
    bit [CH-1:0]  m_hist[$];   // toggle samples of the last DL+1 edges, oldest first
    bit           m_pend[CH];
    logic [W-1:0] m_word[CH];
    bit [CH-1:0]  m_ovf;
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_chan;
    int           m_ptr;

    function automatic void model_reset();
        m_hist = {};
        for (int k = 0; k <= DL; k++) m_hist.push_back('0);
        for (int c = 0; c < CH; c++) begin
            m_pend[c] = 0;
            m_word[c] = '0;
        end
        m_ovf = '0; m_valid = 0; m_data = '0; m_chan = 0; m_ptr = 0;
    endfunction

    function automatic void model_step();
        bit [CH-1:0] ev;
        int g, c;
        if (rst) begin
            model_reset();
            return;
        end
        // A toggle seen at edge n-DL differing from edge n-DL-1 is an event now.
        ev = m_hist[1] ^ m_hist[0];
        m_hist.push_back(toggle_in);
        void'(m_hist.pop_front());
        if (!m_valid || out_ready) begin
            g = -1;
            for (int i = 0; i < CH; i++) begin
`ifdef STROBE_RX_RR_EN
                c = (m_ptr + i) % CH;
`else
                c = i;
`endif
                if (g < 0 && m_pend[c]) g = c;
            end
            if (g >= 0) begin
                m_valid = 1; m_data = m_word[g]; m_chan = g; m_pend[g] = 0;
                m_ptr = (g + 1) % CH;
            end else begin
                m_valid = 0;
            end
        end
        if (ovf_clear) m_ovf = '0;
        for (int k = 0; k < CH; k++) begin
            if (ev[k]) begin
                if (m_pend[k]) m_ovf[k] = 1;
                m_word[k] = data_in[k*W +: W];
                m_pend[k] = 1;
            end
        end
    endfunction

    // One clock: advance the model, then compare the DUT just after the edge.
    task automatic tick();
        @(posedge clk_out);
        model_step();
        #1;
        check("model_valid", {31'd0, out_valid}, {31'd0, m_valid});
        if (m_valid) begin
            check("model_data", {24'd0, out_data}, {24'd0, m_data});
            check("model_chan", {30'd0, out_chan}, m_chan);
        end
        check("model_ovf", {28'd0, ovf_flags}, {28'd0, m_ovf});
    endtask

    task automatic exp_out(input string name, input bit v, input logic [7:0] d, input int c);
        check({name, "_valid"}, {31'd0, out_valid}, {31'd0, v});
        if (v) begin
            check({name, "_data"}, {24'd0, out_data}, {24'd0, d});
            check({name, "_chan"}, {30'd0, out_chan}, c);
        end
    endtask

    typedef struct {
        logic [3:0]  tog;
        logic [31:0] din;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [7:0]  ed;
        int          ec;
        logic [3:0]  eo;
    } vec_t;

    vec_t         vecs[19];
    int           arb_c[5];
    logic [7:0]   arb_d[5];

    initial begin
        // Single strobe on ch2, then three toggles on ch1 under back-pressure.
        vecs[0]  = '{4'b0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 8'h00, 0, 4'b0000};
        vecs[1]  = '{4'b0100, 32'h00A5_0000, 1'b1, 1'b0, 1'b0, 8'h00, 0, 4'b0000};
        vecs[2]  = '{4'b0100, 32'h00A5_0000, 1'b1, 1'b0, 1'b0, 8'h00, 0, 4'b0000};
        vecs[3]  = '{4'b0100, 32'h00A5_0000, 1'b1, 1'b0, 1'b0, 8'h00, 0, 4'b0000};
        vecs[4]  = '{4'b0100, 32'h00A5_0000, 1'b1, 1'b0, 1'b1, 8'hA5, 2, 4'b0000};
        vecs[5]  = '{4'b0100, 32'h00A5_0000, 1'b1, 1'b0, 1'b0, 8'h00, 0, 4'b0000};
        vecs[6]  = '{4'b0110, 32'h00A5_1100, 1'b0, 1'b0, 1'b0, 8'h00, 0, 4'b0000};
        vecs[7]  = '{4'b0110, 32'h00A5_1100, 1'b0, 1'b0, 1'b0, 8'h00, 0, 4'b0000};
        vecs[8]  = '{4'b0110, 32'h00A5_1100, 1'b0, 1'b0, 1'b0, 8'h00, 0, 4'b0000};
        vecs[9]  = '{4'b0100, 32'h00A5_2200, 1'b0, 1'b0, 1'b1, 8'h11, 1, 4'b0000};
        vecs[10] = '{4'b0100, 32'h00A5_2200, 1'b0, 1'b0, 1'b1, 8'h11, 1, 4'b0000};
        vecs[11] = '{4'b0100, 32'h00A5_2200, 1'b0, 1'b0, 1'b1, 8'h11, 1, 4'b0000};
        vecs[12] = '{4'b0110, 32'h00A5_3300, 1'b0, 1'b0, 1'b1, 8'h11, 1, 4'b0000};
        vecs[13] = '{4'b0110, 32'h00A5_3300, 1'b0, 1'b0, 1'b1, 8'h11, 1, 4'b0000};
        vecs[14] = '{4'b0110, 32'h00A5_3300, 1'b0, 1'b0, 1'b1, 8'h11, 1, 4'b0010};
        vecs[15] = '{4'b0110, 32'h00A5_3300, 1'b1, 1'b0, 1'b1, 8'h33, 1, 4'b0010};
        vecs[16] = '{4'b0110, 32'h00A5_3300, 1'b1, 1'b0, 1'b0, 8'h00, 0, 4'b0010};
        vecs[17] = '{4'b0110, 32'h00A5_3300, 1'b1, 1'b1, 1'b0, 8'h00, 0, 4'b0000};
        vecs[18] = '{4'b0110, 32'h00A5_3300, 1'b1, 1'b0, 1'b0, 8'h00, 0, 4'b0000};
`ifdef STROBE_RX_RR_EN
        arb_c = '{0, 1, 2, 3, 0};
        arb_d = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h60};
`else
        arb_c = '{0, 1, 2, 0, 3};
        arb_d = '{8'h50, 8'h51, 8'h52, 8'h60, 8'h53};
`endif

        rst = 1'b1; toggle_in = '0; data_in = '0; out_ready = 1'b1; ovf_clear = 1'b0;
        model_reset();
        tick(); tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", {24'd0, out_data}, 32'd0);
        check("rst_chan", {30'd0, out_chan}, 32'd0);
        check("rst_ovf", {28'd0, ovf_flags}, 32'd0);
        rst = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < 19; i++) begin
            toggle_in = vecs[i].tog; data_in = vecs[i].din;
            out_ready = vecs[i].rdy; ovf_clear = vecs[i].clr;
            tick();
            exp_out($sformatf("tbl%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ec);
            check($sformatf("tbl%0d_ovf", i), {28'd0, ovf_flags}, {28'd0, vecs[i].eo});
        end
        ovf_clear = 1'b0;

        // Back-pressure: ch0 and ch1 pending, stall 10 cycles, then back-to-back.
        toggle_in ^= 4'b0011; data_in[7:0] = 8'h40; data_in[15:8] = 8'h41; out_ready = 1'b0;
        tick(); tick(); tick();
        exp_out("bp_wait", 1'b0, 8'h00, 0);
        tick();
        exp_out("bp_first", 1'b1, 8'h40, 0);
        repeat (10) begin
            tick();
            exp_out("bp_hold", 1'b1, 8'h40, 0);
        end
        out_ready = 1'b1;
        tick(); exp_out("bp_second", 1'b1, 8'h41, 1);
        tick(); exp_out("bp_done", 1'b0, 8'h00, 0);

        // Reset so the arbitration run starts from a fresh pointer.
        rst = 1'b1; toggle_in = '0; data_in = '0;
        tick(); exp_out("rst2", 1'b0, 8'h00, 0);
        tick(); rst = 1'b0;

        // Arbitration: all four channels at once, then a ch0 re-toggle.
        toggle_in = 4'b1111; data_in = 32'h5352_5150; out_ready = 1'b1;
        tick(); tick(); tick();
        exp_out("arb_wait", 1'b0, 8'h00, 0);
        toggle_in[0] = 1'b0; data_in[7:0] = 8'h60;
        for (int k = 0; k < 5; k++) begin
            tick();
            exp_out($sformatf("arb%0d", k), 1'b1, arb_d[k], arb_c[k]);
        end
        tick(); exp_out("arb_done", 1'b0, 8'h00, 0);

        // Grant/event collision on ch3.
        out_ready = 1'b0;
        toggle_in ^= 4'b1100; data_in[23:16] = 8'h82; data_in[31:24] = 8'h70;
        tick(); tick(); tick();
        exp_out("col_wait", 1'b0, 8'h00, 0);
        tick(); exp_out("col_ch2", 1'b1, 8'h82, 2);
        toggle_in[3] = ~toggle_in[3]; data_in[31:24] = 8'h71;
        tick(); exp_out("col_hold", 1'b1, 8'h82, 2);
        tick(); exp_out("col_hold", 1'b1, 8'h82, 2);
        out_ready = 1'b1;
        tick(); exp_out("col_grant", 1'b1, 8'h70, 3);
        check("col_ovf", {28'd0, ovf_flags}, 32'd0);
        tick(); exp_out("col_new", 1'b1, 8'h71, 3);
        tick(); exp_out("col_done", 1'b0, 8'h00, 0);
        check("col_ovf_end", {28'd0, ovf_flags}, 32'd0);

        // Reset mid-operation with a word presented, one pending and an overflow.
        out_ready = 1'b0;
        toggle_in ^= 4'b0011; data_in[7:0] = 8'h90; data_in[15:8] = 8'h91;
        tick(); tick(); tick(); tick();
        exp_out("mid_pres", 1'b1, 8'h90, 0);
        toggle_in[1] = ~toggle_in[1]; data_in[15:8] = 8'h92;
        tick(); tick(); tick();
        check("mid_ovf", {28'd0, ovf_flags}, 32'h2);
        rst = 1'b1; toggle_in = '0; data_in = '0;
        tick();
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_data", {24'd0, out_data}, 32'd0);
        check("mid_rst_chan", {30'd0, out_chan}, 32'd0);
        check("mid_rst_ovf", {28'd0, ovf_flags}, 32'd0);
        rst = 1'b0; out_ready = 1'b1;
        repeat (8) begin
            tick();
            exp_out("mid_after", 1'b0, 8'h00, 0);
        end

        // Randomized run against the model.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 699) == 0);
            if (rst) begin
                toggle_in = '0;
            end else begin
                for (int c = 0; c < CH; c++) begin
                    if ($urandom_range(0, 7) == 0) begin
                        toggle_in[c] = ~toggle_in[c];
                        data_in[c*W +: W] = 8'($urandom);
                    end
                end
            end
            if ((n % 600) < 300) out_ready = ($urandom_range(0, 3) != 0);
            else                 out_ready = ($urandom_range(0, 3) == 0);
            ovf_clear = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
